// File: rtl/shift_add_mult_core.sv
// Iterative shift-add multiplier retiring one multiplier bit per clock, start/busy/done handshake.
// Define SIGNED_MULT_EN for two's-complement operands (magnitude multiply plus result negation).
module shift_add_mult_core #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_step;
  logic [WIDTH:0]     upper_sum;
  logic [CW-1:0]      count;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   load_a;
  logic [WIDTH-1:0]   load_b;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == CW'(WIDTH-1)) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last = (state == RUN) && (count == CW'(WIDTH-1));

  // Upper part stays below 2^WIDTH between steps, so WIDTH+1 bits hold the sum exactly.
  always_comb begin
    upper_sum = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand}) : acc[2*WIDTH:WIDTH];
    acc_step  = {upper_sum, acc[WIDTH-1:0]} >> 1;
  end

`ifdef SIGNED_MULT_EN
  logic sign;

  always_comb begin
    load_a = multiplicand[WIDTH-1] ? (-multiplicand) : multiplicand;
    load_b = multiplier[WIDTH-1]   ? (-multiplier)   : multiplier;
    result = sign ? (-acc_step[2*WIDTH-1:0]) : acc_step[2*WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)       sign <= 1'b0;
    else if (accept) sign <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
  end
`else
  always_comb begin
    load_a = multiplicand;
    load_b = multiplier;
    result = acc_step[2*WIDTH-1:0];
  end
`endif

  // Reset has priority over a pending start; product only moves on the final RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand <= load_a;
        acc   <= {{(WIDTH+1){1'b0}}, load_b};
        count <= '0;
      end else if (state == RUN) begin
        acc   <= acc_step;
        count <= count + CW'(1);
        if (last) product <= result;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/shift_add_mult_core.md
# shift_add_mult_core

Iterative shift-add multiplier core that consumes the registered 64-bit operands produced by the operand/multiplier register stage and produces a double-width product. One multiplier bit is retired per clock. A start/busy/done handshake lets the surrounding structural multiplier sequence operands through it.

## Interface
- WIDTH, 64, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request a multiply; sampled only in IDLE or DONE
- multiplicand  input  WIDTH  operand A, sampled on the accepting edge only
- multiplier  input  WIDTH  operand B, sampled on the accepting edge only
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held stable from done until the next accepted start

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: accept. Latch multiplicand into MCAND. Load the accumulator P (2*WIDTH+1 bits, including a carry bit) with {0, multiplier}. Clear the iteration counter. Go to RUN.
- RUN, each edge:
  - If P[0]=1, the upper WIDTH+1 bits of P become P_upper + MCAND.
  - P then shifts right one bit, with the carry bit shifting in.
  - Counter increments.
  - After the iteration where counter reaches WIDTH-1, go to DONE.
- DONE: done=1 for exactly one cycle. Next state is RUN if start=1 (back-to-back accept, same load as from IDLE), otherwise IDLE.
- start is ignored in RUN. Operand inputs are don't-care outside the accepting edge.
- product = P[2*WIDTH-1:0]. It changes only on the final RUN edge and is otherwise held, including through IDLE.
- Arithmetic is unsigned modulo nothing: the full 2*WIDTH product is always exact. The carry bit never propagates beyond bit 2*WIDTH.
- Reset outputs: busy=0, done=0, product=0. State=IDLE, counter=0.
- Reset mid-operation has priority over everything. The next edge aborts to IDLE, clears product to 0, and deasserts busy/done. No partial result is ever presented.
- start and reset high together: reset wins and the start is dropped.

## Timing
- Edge E0 accepts start. busy is high from E0 through EW (WIDTH edges of RUN).
- product is updated and done rises on edge EW = E0+WIDTH. done falls at EW+1.
- Latency from the accepting edge to done is WIDTH cycles. WIDTH=64 gives 64 cycles.
- Throughput with back-to-back start: one result per WIDTH+1 cycles.
- busy and done are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SIGNED_MULT_EN defined:
  - Operands are two's complement.
  - On accept, both operands are converted to magnitude (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)) and the result sign is latched as A[msb] XOR B[msb].
  - On the final RUN edge the 2*WIDTH result is two's-complement negated before being written when the sign is 1.
  - Latency is unchanged.
- SIGNED_MULT_EN undefined: unsigned operation only. No magnitude or negation logic is present.

## Test plan
- Basic unsigned: reset, then start with A=3, B=5 -> busy for 64 cycles; done pulses at E0+64; product=128'd15; product held at 15 in IDLE.
- Full-scale unsigned: A=B=64'hFFFF_FFFF_FFFF_FFFF -> product=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Zero and back-to-back:
  - A=0, B=64'h1234 -> product=0.
  - Assert start again in the DONE cycle with A=7, B=6 -> busy the next cycle; product=42 after 64 more cycles.
- Start while busy plus reset mid-op:
  - Pulse start with new operands at E0+10 -> ignored; result still the first operands' product.
  - A separate run with reset at E0+20 -> next cycle busy=0, done=0, product=0; no done pulse follows.
- SIGNED_MULT_EN:
  - A=-3, B=5 -> product=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1.
  - A=64'h8000_0000_0000_0000, B=-1 -> product=128'h0000_0000_0000_0000_8000_0000_0000_0000.
  - Latency is still 64 cycles.
